// File: rtl/aes_seq_ctrl.sv
// Host-side sequencer for the AES wrapper's control/write/read port: config, key load and init,
// block load and start, status polling and result readout, with a cached-key fast path.
module aes_seq_ctrl #(
  parameter int GUARD   = 3,
  parameter int TIMEOUT = 4096,
  parameter int RD_LAT  = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [255:0] req_key,
  input  logic         req_keylen,
  input  logic         req_encdec,
  input  logic         req_rekey,
  input  logic [127:0] req_block,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic [3:0]   aes_control,
  output logic [15:0]  aes_write_data,
  input  logic [7:0]   aes_data_out
);

  localparam int CW = $clog2(TIMEOUT + GUARD + RD_LAT + 32);

  localparam logic [3:0] OP_NOP        = 4'd0;
  localparam logic [3:0] OP_WR_BLOCK   = 4'd1;
  localparam logic [3:0] OP_WR_KEY     = 4'd2;
  localparam logic [3:0] OP_STATUS     = 4'd3;
  localparam logic [3:0] OP_CONFIG     = 4'd4;
  localparam logic [3:0] OP_START      = 4'd5;
  localparam logic [3:0] OP_RESULT_OUT = 4'd6;

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_KEY_WR, S_KEY_INIT, S_KEY_GUARD, S_KEY_WAIT,
    S_BLK_WR, S_NEXT, S_BLK_GUARD, S_BLK_WAIT, S_RD, S_RESP
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [255:0]    key_reg, cached_key_reg;
  logic [127:0]    block_reg;
  logic            keylen_reg, encdec_reg, do_key_reg;
  logic            cached_keylen_reg, key_cached_reg;
  logic            accept, key_ok, blk_ok, poll_expired, timeout_hit, rd_capture;
  logic            cfg_keylen, cfg_encdec;
  logic [3:0]      rd_idx;
  logic [3:0]      ctrl_next;
  logic [15:0]     wdata_next;
  logic [15:0]     key_words [16];
  logic [15:0]     blk_words [8];

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_key_words
      assign key_words[gi] = key_reg[255-16*gi -: 16];
    end
    for (genvar gi = 0; gi < 8; gi++) begin : g_blk_words
      assign blk_words[gi] = block_reg[127-16*gi -: 16];
    end
  endgenerate

  always_comb begin
    accept       = req_valid && req_ready;
    key_ok       = aes_data_out[0];
    blk_ok       = aes_data_out[1];
    poll_expired = (cnt_reg == CW'(TIMEOUT - 1));
    timeout_hit  = poll_expired && (((state_reg == S_KEY_WAIT) && !key_ok) ||
                                    ((state_reg == S_BLK_WAIT) && !blk_ok));
    rd_capture   = (state_reg == S_RD) && (cnt_reg >= CW'(RD_LAT));
    rd_idx       = cnt_reg[3:0] - 4'(RD_LAT);
    // CONFIG is issued the cycle after accept, before the captured copy is visible
    cfg_keylen   = (state_reg == S_IDLE) ? req_keylen : keylen_reg;
    cfg_encdec   = (state_reg == S_IDLE) ? req_encdec : encdec_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CW'(1);
    case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
        if (accept) state_next = S_CFG;
      end
      S_CFG: begin
        cnt_next   = '0;
        state_next = do_key_reg ? S_KEY_WR : S_BLK_WR;
      end
      S_KEY_WR: if (cnt_reg == CW'(15)) begin
        state_next = S_KEY_INIT;
        cnt_next   = '0;
      end
      S_KEY_INIT: begin
        cnt_next   = '0;
        state_next = (GUARD > 0) ? S_KEY_GUARD : S_KEY_WAIT;
      end
      S_KEY_GUARD: if (cnt_reg == CW'(GUARD - 1)) begin
        state_next = S_KEY_WAIT;
        cnt_next   = '0;
      end
      S_KEY_WAIT: begin
        if (key_ok) begin
          state_next = S_BLK_WR;
          cnt_next   = '0;
        end else if (poll_expired) begin
          state_next = S_RESP;
          cnt_next   = '0;
        end
      end
      S_BLK_WR: if (cnt_reg == CW'(7)) begin
        state_next = S_NEXT;
        cnt_next   = '0;
      end
      S_NEXT: begin
        cnt_next   = '0;
        state_next = (GUARD > 0) ? S_BLK_GUARD : S_BLK_WAIT;
      end
      S_BLK_GUARD: if (cnt_reg == CW'(GUARD - 1)) begin
        state_next = S_BLK_WAIT;
        cnt_next   = '0;
      end
      S_BLK_WAIT: begin
        if (blk_ok) begin
          state_next = S_RD;
          cnt_next   = '0;
        end else if (poll_expired) begin
          state_next = S_RESP;
          cnt_next   = '0;
        end
      end
      S_RD: if (cnt_reg == CW'(15 + RD_LAT)) begin
        state_next = S_RESP;
        cnt_next   = '0;
      end
      S_RESP: begin
        cnt_next = '0;
        if (rsp_ready) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Bus outputs are decoded from the next state so they register in step with it
  always_comb begin
    ctrl_next  = OP_NOP;
    wdata_next = 16'h0000;
    case (state_next)
      S_CFG: begin
        ctrl_next  = OP_CONFIG;
        wdata_next = {14'h0, cfg_keylen, cfg_encdec};
      end
      S_KEY_WR: begin
        ctrl_next  = OP_WR_KEY;
        wdata_next = key_words[cnt_next[3:0]];
      end
      S_KEY_INIT: begin
        ctrl_next  = OP_START;
        wdata_next = 16'h0001;
      end
      S_KEY_WAIT, S_BLK_WAIT: ctrl_next = OP_STATUS;
      S_BLK_WR: begin
        ctrl_next  = OP_WR_BLOCK;
        wdata_next = blk_words[cnt_next[2:0]];
      end
      S_NEXT: begin
        ctrl_next  = OP_START;
        wdata_next = 16'h0002;
      end
      S_RD: if (cnt_next < CW'(16)) ctrl_next = OP_RESULT_OUT;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready         <= 1'b1;
      rsp_valid         <= 1'b0;
      rsp_err           <= 1'b0;
      rsp_data          <= '0;
      aes_control       <= OP_NOP;
      aes_write_data    <= 16'h0000;
      key_reg           <= '0;
      block_reg         <= '0;
      keylen_reg        <= 1'b0;
      encdec_reg        <= 1'b0;
      do_key_reg        <= 1'b0;
      cached_key_reg    <= '0;
      cached_keylen_reg <= 1'b0;
      key_cached_reg    <= 1'b0;
    end else begin
      aes_control    <= ctrl_next;
      aes_write_data <= wdata_next;
      req_ready      <= (state_next == S_IDLE);
      rsp_valid      <= (state_next == S_RESP);
      if (accept) begin
        key_reg    <= req_key;
        block_reg  <= req_block;
        keylen_reg <= req_keylen;
        encdec_reg <= req_encdec;
        do_key_reg <= req_rekey || !key_cached_reg ||
                      (req_keylen != cached_keylen_reg) || (req_key != cached_key_reg);
      end
      if ((state_reg == S_KEY_WAIT) && key_ok) begin
        key_cached_reg    <= 1'b1;
        cached_key_reg    <= key_reg;
        cached_keylen_reg <= keylen_reg;
      end
      if (rd_capture) rsp_data[{~rd_idx, 3'b000} +: 8] <= aes_data_out;
      // The wrapper's key state is unknown after a timeout, so force a reload next time
      if (timeout_hit) begin
        rsp_err        <= 1'b1;
        rsp_data       <= '0;
        key_cached_reg <= 1'b0;
      end
      if ((state_reg == S_RESP) && rsp_ready) rsp_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// Testbench for aes_seq_ctrl: behavioural AES wrapper stand-in plus a request-level reference model.
module tb_aes_seq_ctrl;
  localparam int GUARD = 3, TIMEOUT = 16, RD_LAT = 1;
  localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_ready, req_keylen = 1'b0, req_encdec = 1'b0, req_rekey = 1'b0;
  logic [255:0] req_key = '0;
  logic [127:0] req_block = '0, rsp_data;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [3:0] aes_control;
  logic [15:0] aes_write_data;
  logic [7:0] aes_data_out;

  always #5 clk = ~clk;

  aes_seq_ctrl #(.GUARD(GUARD), .TIMEOUT(TIMEOUT), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .req_keylen(req_keylen), .req_encdec(req_encdec), .req_rekey(req_rekey),
    .req_block(req_block), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .aes_control(aes_control), .aes_write_data(aes_write_data),
    .aes_data_out(aes_data_out)
  );

  // Stand-in cipher: exact FIPS-197 answers for the known vectors, a keyed byte shuffle otherwise
  function automatic logic [127:0] cipher(input logic [255:0] k, input logic kl, input logic enc,
                                          input logic [127:0] b);
    logic [127:0] klo, x;
    if (!kl && k[255:128] == K128) begin
      if (enc && b == PT) return CT128;
      if (!enc && b == CT128) return PT;
    end
    if (kl && k == K256) begin
      if (enc && b == PT) return CT256;
      if (!enc && b == CT256) return PT;
    end
    klo = kl ? k[127:0] : 128'h0;
    if (enc) begin
      x = b ^ k[255:128] ^ klo;
      return {x[119:0], x[127:120]};
    end
    x = {b[7:0], b[127:8]} ^ k[255:128] ^ klo;
    return x;
  endfunction

  // Wrapper model
  logic [15:0]  w_key_mem [16];
  logic [15:0]  w_blk_mem [8];
  int           w_key_idx = 0, w_blk_idx = 0, w_rd_idx = 0, w_rtmr = 0, w_vtmr = 0;
  logic         w_cfg_kl = 1'b0, w_cfg_enc = 1'b0, w_sched_kl = 1'b0, w_ready = 1'b0, w_valid = 1'b0;
  logic [255:0] w_sched_key = '0;
  logic [127:0] w_result = '0;
  logic         stub_dead = 1'b0;
  int           n_wrkey = 0, n_init = 0, n_status = 0;

  function automatic logic [255:0] mem_key();
    logic [255:0] k;
    for (int i = 0; i < 16; i++) k[255-16*i -: 16] = w_key_mem[i];
    return k;
  endfunction

  function automatic logic [127:0] mem_blk();
    logic [127:0] b;
    for (int i = 0; i < 8; i++) b[127-16*i -: 16] = w_blk_mem[i];
    return b;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      w_key_idx <= 0; w_blk_idx <= 0; w_rd_idx <= 0; w_rtmr <= 0; w_vtmr <= 0;
      w_ready <= 1'b0; w_valid <= 1'b0; aes_data_out <= 8'h00;
    end else begin
      aes_data_out <= 8'h00;
      if (w_rtmr > 0) begin
        w_rtmr <= w_rtmr - 1;
        if (w_rtmr == 1) w_ready <= 1'b1;
      end
      if (w_vtmr > 0) begin
        w_vtmr <= w_vtmr - 1;
        if (w_vtmr == 1) w_valid <= 1'b1;
      end
      case (aes_control)
        4'd4: begin w_cfg_kl <= aes_write_data[1]; w_cfg_enc <= aes_write_data[0]; end
        4'd2: begin
          w_key_mem[w_key_idx] <= aes_write_data;
          w_key_idx <= (w_key_idx + 1) % 16;
          n_wrkey <= n_wrkey + 1;
        end
        4'd1: begin
          w_blk_mem[w_blk_idx] <= aes_write_data;
          w_blk_idx <= (w_blk_idx + 1) % 8;
        end
        4'd5: begin
          if (aes_write_data == 16'h0001) begin
            w_sched_key <= mem_key(); w_sched_kl <= w_cfg_kl; w_ready <= 1'b0;
            w_rtmr <= 2 + int'($urandom_range(0, 6)); n_init <= n_init + 1;
          end else if (aes_write_data == 16'h0002) begin
            w_valid <= 1'b0; w_vtmr <= 2 + int'($urandom_range(0, 6));
            w_result <= cipher(w_sched_key, w_sched_kl, w_cfg_enc, mem_blk());
          end
        end
        4'd3: begin
          n_status <= n_status + 1;
          aes_data_out <= stub_dead ? 8'h00 : {6'b0, w_valid, w_ready};
        end
        4'd6: begin
          aes_data_out <= w_result[127-8*w_rd_idx -: 8];
          w_rd_idx <= (w_rd_idx + 1) % 16;
        end
        default: ;
      endcase
    end
  end

  // Reference model and bookkeeping
  int n_checks = 0, n_errs = 0;
  logic m_cached = 1'b0, m_kl = 1'b0;
  logic [255:0] m_key = '0;
  logic e_dokey, e_timeout, e_err, e_kl, e_enc;
  logic [127:0] e_data, last_data;
  logic last_err;
  int s_wrkey, s_init, s_status, last_wrkey, last_init, last_polls;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [255:0] k, input logic kl, input logic enc, input logic rk,
                      input logic [127:0] b);
    int w = 0;
    @(negedge clk);
    while (!req_ready && w < 200) begin @(negedge clk); w++; end
    chk("req_ready_idle", req_ready, 1);
    req_key = k; req_keylen = kl; req_encdec = enc; req_rekey = rk; req_block = b; req_valid = 1'b1;
    e_dokey   = rk || !m_cached || (kl != m_kl) || (k != m_key);
    e_timeout = stub_dead;
    e_err     = stub_dead;
    e_data    = stub_dead ? 128'h0 : cipher(k, kl, enc, b);
    e_kl = kl; e_enc = enc;
    if (stub_dead) m_cached = 1'b0;
    else begin m_cached = 1'b1; m_key = k; m_kl = kl; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    s_wrkey = n_wrkey; s_init = n_init; s_status = n_status;
  endtask

  task automatic collect(input int hold, input string tag);
    int n = 0, lat_exp;
    logic stable;
    logic [127:0] d0;
    do begin
      @(negedge clk); n++;
      if (n == 1) begin
        chk({tag, "/req_ready_busy"}, req_ready, 0);
        chk({tag, "/cfg_op"}, aes_control, 4);
        chk({tag, "/cfg_data"}, aes_write_data, {14'h0, e_kl, e_enc});
      end
    end while (!rsp_valid && n < 1000);
    chk({tag, "/rsp_valid"}, rsp_valid, 1);
    chk({tag, "/rsp_data"}, rsp_data, e_data);
    chk({tag, "/rsp_err"}, rsp_err, e_err);
    last_data = rsp_data; last_err = rsp_err;
    last_wrkey = n_wrkey - s_wrkey; last_init = n_init - s_init; last_polls = n_status - s_status;
    chk({tag, "/wr_key_ops"}, last_wrkey, e_dokey ? 16 : 0);
    chk({tag, "/init_ops"}, last_init, e_dokey ? 1 : 0);
    lat_exp = 1 + (e_dokey ? 17 + GUARD : 0) + ((e_timeout && e_dokey) ? 0 : 9 + GUARD)
              + last_polls + (e_timeout ? 0 : 16 + RD_LAT);
    chk({tag, "/latency"}, n - 1, lat_exp);
    d0 = rsp_data;
    stable = rsp_valid && !req_ready && (aes_control == 4'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      stable = stable && rsp_valid && (rsp_data == d0) && !req_ready && (aes_control == 4'd0);
    end
    chk({tag, "/resp_hold"}, stable, 1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk({tag, "/rsp_valid_clr"}, rsp_valid, 0);
    chk({tag, "/rsp_err_clr"}, rsp_err, 0);
    chk({tag, "/req_ready_back"}, req_ready, 1);
    $display("txn %s: key_ops=%0d init=%0d polls=%0d latency=%0d data=%h err=%0d",
             tag, last_wrkey, last_init, last_polls, n - 1, last_data, last_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] k;
    logic [127:0] b;
    logic kl, enc, rk;
    int w;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset/req_ready", req_ready, 1);
    chk("reset/rsp_valid", rsp_valid, 0);
    chk("reset/rsp_err", rsp_err, 0);
    chk("reset/rsp_data", rsp_data, 0);
    chk("reset/aes_control", aes_control, 0);
    chk("reset/aes_write_data", aes_write_data, 0);

    send({K128, 128'h0}, 1'b0, 1'b1, 1'b0, PT);
    collect(0, "fips128_enc");
    chk("fips128_enc/ct", last_data, CT128);
    chk("fips128_enc/keyops", last_wrkey, 16);
    chk("fips128_enc/init", last_init, 1);

    send({K128, 128'h0}, 1'b0, 1'b0, 1'b0, CT128);
    collect(0, "fips128_dec_cached");
    chk("fips128_dec/pt", last_data, PT);
    chk("fips128_dec/keyops", last_wrkey, 0);
    chk("fips128_dec/init", last_init, 0);

    send(K256, 1'b1, 1'b1, 1'b0, PT);
    collect(20, "fips256_enc_hold");
    chk("fips256_enc/ct", last_data, CT256);

    for (int it = 0; it < 12; it++) begin
      if (m_cached && $urandom_range(0, 1) == 1) begin
        k = m_key; kl = m_kl;
      end else begin
        kl = 1'($urandom_range(0, 1));
        k = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        if (!kl) k[127:0] = '0;
      end
      enc = 1'($urandom_range(0, 1));
      rk  = ($urandom_range(0, 3) == 0);
      b   = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(k, kl, enc, rk, b);
      collect(int'($urandom_range(0, 3)), $sformatf("rand%0d", it));
    end

    stub_dead = 1'b1;
    k = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
    b = {$urandom(), $urandom(), $urandom(), $urandom()};
    send(k, 1'b0, 1'b1, 1'b1, b);
    collect(0, "timeout");
    chk("timeout/err", last_err, 1);
    chk("timeout/data", last_data, 0);
    chk("timeout/polls", last_polls, TIMEOUT);
    stub_dead = 1'b0;
    send(k, 1'b0, 1'b1, 1'b0, b);
    collect(0, "after_timeout");
    chk("after_timeout/keyops", last_wrkey, 16);

    send({K128, 128'h0}, 1'b0, 1'b1, 1'b1, PT);
    w = 0;
    while ((n_wrkey - s_wrkey) < 5 && w < 100) begin @(negedge clk); w++; end
    chk("midkey/reached_word5", n_wrkey - s_wrkey, 5);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_cached = 1'b0;
    @(negedge clk);
    chk("midkey/req_ready", req_ready, 1);
    chk("midkey/aes_control", aes_control, 0);
    send({K128, 128'h0}, 1'b0, 1'b1, 1'b0, PT);
    collect(0, "after_reset");
    chk("after_reset/ct", last_data, CT128);
    chk("after_reset/keyops", last_wrkey, 16);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
